// File: rtl/config_spi_loader.sv
`default_nettype none
// ============================================================================
// Module      : config_spi_loader
// Description : Upstream feeder for the configuration shift register.
//               Synchronises an external 3-wire SPI-style frame (sclk, cs_n,
//               mosi) into clk. Each sclk rising edge inside a frame becomes
//               a one-cycle serialEn strobe carrying the sampled bit on
//               serialIn. The bits in each frame are counted, and the frame
//               is flagged as complete (configValid) or malformed
//               (frameError). The store tail bit is returned on spiMiso.
// Ports       : clk          system clock
//               reset        asynchronous active-high reset
//               spiSclk      external serial clock (async)
//               spiCsN       external chip select, active low (async)
//               spiMosi      external serial data in (async)
//               spiMiso      registered copy of serialOut
//               serialEn     one-cycle shift strobe to the config store
//               serialIn     data bit accompanying serialEn
//               serialOut    tail bit of the config store shift register
//               configValid  last frame had exactly SHIFT_REG_SIZE bits
//               frameError   last frame had a wrong bit count
// Revision    : 1.0 - initial release
// ============================================================================
module config_spi_loader #(
    parameter int SHIFT_REG_SIZE = 18,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic spiSclk,
    input  logic spiCsN,
    input  logic spiMosi,
    output logic spiMiso,
    output logic serialEn,
    output logic serialIn,
    input  logic serialOut,
    output logic configValid,
    output logic frameError
);

    localparam int COUNT_WIDTH = $clog2(SHIFT_REG_SIZE + 2);
    localparam logic [COUNT_WIDTH-1:0] c_full = COUNT_WIDTH'(SHIFT_REG_SIZE);
    localparam logic [COUNT_WIDTH-1:0] c_sat  = COUNT_WIDTH'(SHIFT_REG_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers and edge history
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_hist;
    logic                   r_cs_hist;

    // Fills with ones after reset. Edges are ignored until the synchronisers
    // have been flushed with real pin values, so a cs_n that is already low
    // at reset release is not seen as a falling edge.
    logic [SYNC_STAGES:0]   r_warm;

    logic w_ready;
    logic w_sclk_rise;
    logic w_cs_fall;
    logic w_cs_rise;

    // Edge detects registered once more before the FSM; mosi travels
    // alongside so serialIn stays aligned with its strobe.
    logic r_sclk_rise_q;
    logic r_cs_fall_q;
    logic r_cs_rise_q;
    logic r_mosi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync   <= '0;
            r_cs_sync     <= '1;
            r_mosi_sync   <= '0;
            r_sclk_hist   <= 1'b0;
            r_cs_hist     <= 1'b1;
            r_warm        <= '0;
            r_sclk_rise_q <= 1'b0;
            r_cs_fall_q   <= 1'b0;
            r_cs_rise_q   <= 1'b0;
            r_mosi_q      <= 1'b0;
        end else begin
            r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], spiSclk};
            r_cs_sync     <= {r_cs_sync[SYNC_STAGES-2:0], spiCsN};
            r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], spiMosi};
            r_sclk_hist   <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_hist     <= r_cs_sync[SYNC_STAGES-1];
            r_warm        <= {r_warm[SYNC_STAGES-1:0], 1'b1};
            r_sclk_rise_q <= w_sclk_rise;
            r_cs_fall_q   <= w_cs_fall;
            r_cs_rise_q   <= w_cs_rise;
            r_mosi_q      <= r_mosi_sync[SYNC_STAGES-1];
        end
    end

    assign w_ready     = r_warm[SYNC_STAGES];
    assign w_sclk_rise = w_ready &  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_hist;
    assign w_cs_fall   = w_ready & ~r_cs_sync[SYNC_STAGES-1]   &  r_cs_hist;
    assign w_cs_rise   = w_ready &  r_cs_sync[SYNC_STAGES-1]   & ~r_cs_hist;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_nxt;
    logic                   r_serial_en;
    logic                   w_serial_en_nxt;
    logic                   r_serial_in;
    logic                   w_serial_in_nxt;
    logic                   r_cfg_valid;
    logic                   w_cfg_valid_nxt;
    logic                   r_frame_err;
    logic                   w_frame_err_nxt;
    logic                   r_miso;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_serial_en <= 1'b0;
            r_serial_in <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_serial_en <= w_serial_en_nxt;
            r_serial_in <= w_serial_in_nxt;
            r_cfg_valid <= w_cfg_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_miso      <= serialOut;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_serial_en_nxt = 1'b0;
        w_serial_in_nxt = r_serial_in;
        w_cfg_valid_nxt = r_cfg_valid;
        w_frame_err_nxt = r_frame_err;
        case (r_state)
            S_IDLE: begin
                if (r_cs_fall_q) begin
                    w_count_nxt     = '0;
                    w_cfg_valid_nxt = 1'b0;
                    w_frame_err_nxt = 1'b0;
                    w_state_nxt     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // cs_n rising wins; a coincident sclk edge is dropped.
                if (r_cs_rise_q) begin
                    w_state_nxt = S_CHECK;
                end else if (r_sclk_rise_q) begin
                    w_serial_en_nxt = 1'b1;
                    w_serial_in_nxt = r_mosi_q;
                    // Saturate one past full so an overrun is never aliased
                    // back onto a legal count.
                    if (r_count != c_sat) begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (r_count == c_full) begin
                    w_cfg_valid_nxt = 1'b1;
                end else begin
                    w_frame_err_nxt = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign serialEn    = r_serial_en;
    assign serialIn    = r_serial_in;
    assign configValid = r_cfg_valid;
    assign frameError  = r_frame_err;
    assign spiMiso     = r_miso;

endmodule
`default_nettype wire

// File: tb/tb_config_spi_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_config_spi_loader
// Description : Self-checking bench for config_spi_loader. Stimulus pushes
//               the expected bit and arrival cycle of every strobe into a
//               queue; a monitor pops and compares on each serialEn pulse.
//               A small 18-bit model store drives serialOut.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_spi_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spiSclk = 1'b0;
    logic spiCsN = 1'b1;
    logic spiMosi = 1'b0;
    logic spiMiso;
    logic serialEn;
    logic serialIn;
    logic serialOut;
    logic configValid;
    logic frameError;

    config_spi_loader dut (
        .clk         (clk),
        .reset       (reset),
        .spiSclk     (spiSclk),
        .spiCsN      (spiCsN),
        .spiMosi     (spiMosi),
        .spiMiso     (spiMiso),
        .serialEn    (serialEn),
        .serialIn    (serialIn),
        .serialOut   (serialOut),
        .configValid (configValid),
        .frameError  (frameError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        int   t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Model config store feeding serialOut.
    logic [17:0] model = '0;
    logic        load = 1'b0;
    logic        prev_so = 1'b0;
    logic        mon_miso = 1'b0;

    assign serialOut = model[17];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        prev_so <= serialOut;
        if (load) model <= 18'h3FFFF;
        else if (serialEn) model <= {model[16:0], serialIn};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (serialEn === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got serialEn=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("serialIn", {31'd0, serialIn}, {31'd0, e.b});
                chk("pulse_cycle", cyc, e.t);
            end
        end
        if (mon_miso && !reset) chk("miso_follow", {31'd0, spiMiso}, {31'd0, prev_so});
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sclk period, half-period 8 clk. A strobe is expected 4 cycles
    // after the cycle the pin rises: first sampling edge + 3.
    task automatic send_bit(input logic b, input bit expect_pulse,
                            input bit sample_miso, input logic miso_exp);
        spiMosi = b;
        wait_cyc(8);
        spiSclk = 1'b1;
        if (sample_miso) chk("miso_readback", {31'd0, spiMiso}, {31'd0, miso_exp});
        if (expect_pulse) q.push_back('{b, cyc + 4});
        wait_cyc(8);
        spiSclk = 1'b0;
    endtask

    task automatic cs_low();
        spiCsN = 1'b0;
        wait_cyc(6);
    endtask

    task automatic cs_high();
        wait_cyc(8);
        spiCsN = 1'b1;
        wait_cyc(12);
        chk("pending_pulses", q.size(), 0);
    endtask

    task automatic send_frame(input logic [31:0] pat, input int n, input bit rb);
        cs_low();
        for (int i = n - 1; i >= 0; i--) send_bit(pat[i], 1'b1, rb, 1'b1);
        cs_high();
    endtask

    logic [31:0] pat;

    initial begin
        // Reset and idle
        wait_cyc(4);
        chk("rst_serialEn", {31'd0, serialEn}, 0);
        chk("rst_serialIn", {31'd0, serialIn}, 0);
        chk("rst_spiMiso", {31'd0, spiMiso}, 0);
        chk("rst_configValid", {31'd0, configValid}, 0);
        chk("rst_frameError", {31'd0, frameError}, 0);
        reset = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0, 1'b0, 1'b0);
        wait_cyc(6);
        chk("idle_configValid", {31'd0, configValid}, 0);
        chk("idle_frameError", {31'd0, frameError}, 0);

        // Valid 18-bit frame
        send_frame(32'h2A5C3, 18, 1'b0);
        chk("valid_configValid", {31'd0, configValid}, 1);
        chk("valid_frameError", {31'd0, frameError}, 0);

        // Zero-bit frame
        cs_low();
        cs_high();
        chk("zero_configValid", {31'd0, configValid}, 0);
        chk("zero_frameError", {31'd0, frameError}, 1);

        // Short frame, 17 bits
        send_frame(32'h1B2C5, 17, 1'b0);
        chk("short_configValid", {31'd0, configValid}, 0);
        chk("short_frameError", {31'd0, frameError}, 1);

        // Overrun, 20 bits; csFall must clear the previous error first
        cs_low();
        wait_cyc(4);
        chk("csfall_clears_frameError", {31'd0, frameError}, 0);
        pat = 32'hABCDE;
        for (int i = 19; i >= 0; i--) send_bit(pat[i], 1'b1, 1'b0, 1'b0);
        cs_high();
        chk("overrun_configValid", {31'd0, configValid}, 0);
        chk("overrun_frameError", {31'd0, frameError}, 1);

        // Readback: store preloaded with ones, zeros shifted in
        @(posedge clk); #1 load = 1'b1;
        wait_cyc(1);
        load = 1'b0;
        wait_cyc(2);
        mon_miso = 1'b1;
        send_frame(32'h0, 18, 1'b1);
        chk("readback_drained_miso", {31'd0, spiMiso}, 0);
        chk("readback_configValid", {31'd0, configValid}, 1);
        mon_miso = 1'b0;

        // Async reset at bit 9 of a frame
        pat = 32'h2A5C3;
        cs_low();
        for (int i = 17; i >= 9; i--) send_bit(pat[i], 1'b1, 1'b0, 1'b0);
        spiMosi = pat[8];
        wait_cyc(8);
        spiSclk = 1'b1;
        q.push_back('{pat[8], cyc + 4});
        repeat (4) @(posedge clk);
        #7 reset = 1'b1;
        #1;
        chk("async_rst_serialEn", {31'd0, serialEn}, 0);
        chk("async_rst_serialIn", {31'd0, serialIn}, 0);
        chk("async_rst_configValid", {31'd0, configValid}, 0);
        chk("async_rst_frameError", {31'd0, frameError}, 0);
        wait_cyc(3);
        spiSclk = 1'b0;
        reset = 1'b0;
        // cs_n still low: neither the flush nor further sclk may start a frame
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_configValid", {31'd0, configValid}, 0);
        chk("post_rst_frameError", {31'd0, frameError}, 0);
        cs_high();
        chk("post_rst_cs_high_frameError", {31'd0, frameError}, 0);
        send_frame(32'h15A3C, 18, 1'b0);
        chk("post_rst_valid_configValid", {31'd0, configValid}, 1);
        chk("post_rst_valid_frameError", {31'd0, frameError}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
